// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host plus the instruction-memory write port
// driven by imem_loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: host byte stream -> little-endian 32-bit words -> imem writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  output logic         core_reset,
  output logic         done,
  output logic         error
);

  localparam int unsigned WIDX_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [15:0]         r_count;
  logic [1:0]          r_bidx;
  logic [WIDX_W-1:0]   r_widx;
  logic [23:0]         r_word;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_core_reset;
  logic                r_done;
  logic                r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic                w_in_ready;
  logic                w_accept;
  logic [15:0]         w_count;
  logic                w_last;

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_HDR0, S_HDR1, S_DATA: w_in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                 w_in_ready = 1'b1;
`endif
      default:                w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_count  = {bus.in_data, r_count[7:0]};
  // Compared as widx+1 == N so an N of zero never underflows.
  assign w_last   = ((32'(r_widx) + 32'd1) == 32'(r_count));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_HDR0;
      r_count      <= '0;
      r_bidx       <= '0;
      r_widx       <= '0;
      r_word       <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_HDR0: begin
`ifdef LOADER_CHECKSUM_EN
          r_csum <= '0;
`endif
          if (w_accept) begin
            r_count[7:0] <= bus.in_data;
            r_state      <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (w_accept) begin
            r_count[15:8] <= bus.in_data;
            r_bidx        <= '0;
            r_widx        <= '0;
            if (w_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state      <= S_CSUM;
`else
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
`endif
            end else if (32'(w_count) > DEPTH) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            // Bytes shift in from the top, so the first byte ends up in [7:0].
            r_word <= {bus.in_data, r_word[23:8]};
            r_bidx <= r_bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ bus.in_data;
`endif
            if (r_bidx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= 32'({r_widx, 2'b00});
              r_wdata <= {bus.in_data, r_word};
              r_state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          r_widx <= r_widx + 1'b1;
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            r_state      <= S_CSUM;
`else
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_core_reset <= 1'b0;
`endif
          end else begin
            r_state <= S_DATA;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            if (bus.in_data == r_csum) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        S_DONE: r_state <= S_DONE;
        S_ERR:  r_state <= S_ERR;

        default: begin
          r_state <= S_ERR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign core_reset     = r_core_reset;
  assign done           = r_done;
  assign error          = r_error;

endmodule
